// File: rtl/mat_pkg.sv
// Shared definitions for the systolic-array operand feeder: default sizes,
// the per-lane operand type and the feeder state encoding.
package mat_pkg;

  localparam int MAT_N      = 4;
  localparam int MAT_DATA_W = 8;
  localparam int MAT_K_MAX  = 16;

  typedef logic [MAT_DATA_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feed_state_e;

endpackage

// File: rtl/skew_lane.sv
// Fixed-depth delay chain carrying one lane's operand and its valid flag.
// Data shifts every cycle; the valid bit travels alongside it.
module skew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/mat_skew_feeder.sv
// Diagonal-skew operand feeder: lane i lags lane 0 by i cycles, one frame at a time.
// Optional macro SKEW_ZERO_FILL_EN forces invalid output lanes to zero.
module mat_skew_feeder
  import mat_pkg::*;
#(
  parameter int N      = MAT_N,
  parameter int DATA_W = MAT_DATA_W,
  parameter int K_MAX  = MAT_K_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                frame_done,
  output logic                len_err
);

  localparam int CNT_W = $clog2(K_MAX + 1);
  localparam int DRN_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(K_MAX);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(N - 1);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

  feed_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
  logic [DRN_W-1:0]   r_drain, w_drain_next;
  logic               r_done, w_done_next;
  logic               r_len_err, w_len_err_next;
  logic               w_accept;
  logic [N*DATA_W-1:0] w_lane_in;
  logic [N*DATA_W-1:0] w_lane_data;
  logic [N-1:0]        w_lane_valid;

  assign in_ready   = (r_state != DRAIN);
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign frame_done = r_done;
  assign len_err    = r_len_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_drain   <= '0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_drain   <= w_drain_next;
      r_done    <= w_done_next;
      r_len_err <= w_len_err_next;
    end
  end

  // The drain leaves DRAIN on the edge that moves lane N-1's final beat to
  // the output, so frame_done registers on that same edge.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_drain_next   = r_drain;
    w_done_next    = 1'b0;
    w_len_err_next = 1'b0;
    case (r_state)
      IDLE, STREAM: begin
        if (w_accept) begin
          w_cnt_next = w_cnt_inc;
          if (in_last || (w_cnt_inc == CNT_MAX)) begin
            w_state_next   = DRAIN;
            w_drain_next   = DRN_LOAD;
            w_len_err_next = !in_last;
          end else begin
            w_state_next = STREAM;
          end
        end
      end
      DRAIN: begin
        if (r_drain == DRN_ONE) begin
          w_state_next = IDLE;
          w_drain_next = '0;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_drain_next = r_drain - DRN_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_drain_next = '0;
      end
    endcase
  end

  // Unaccepted cycles shift zeros in, so in_data never leaks into the chain.
  assign w_lane_in = w_accept ? in_data : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_lane #(
      .DEPTH (gi + 1),
      .W     (DATA_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_data  (w_lane_in[gi*DATA_W +: DATA_W]),
      .i_valid (w_accept),
      .o_data  (w_lane_data[gi*DATA_W +: DATA_W]),
      .o_valid (w_lane_valid[gi])
    );
  end

  assign out_valid = w_lane_valid;

`ifdef SKEW_ZERO_FILL_EN
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[i*DATA_W +: DATA_W] = w_lane_valid[i] ? w_lane_data[i*DATA_W +: DATA_W] : '0;
    end
  end
`else
  assign out_data = w_lane_data;
`endif

endmodule

// File: tb/tb_mat_skew_feeder.sv
// Directed self-checking bench for mat_skew_feeder (N=4, DATA_W=8, K_MAX=16).
// Honours SKEW_ZERO_FILL_EN by also checking invalid lanes read as zero.
module tb_mat_skew_feeder;
  import mat_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int KMAX  = 16;
  localparam int MAXC  = 24;

  logic          clk;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [N*DW-1:0] inData;
  logic          inLast;
  logic [N*DW-1:0] outData;
  logic [N-1:0]  outValid;
  logic          frameDone;
  logic          lenErr;

  int checkCount;
  int failCount;

  logic            stV [MAXC];
  logic            stL [MAXC];
  logic            stR [MAXC];
  logic [N*DW-1:0] stD [MAXC];
  logic            exR [MAXC];
  logic            exF [MAXC];
  logic            exE [MAXC];
  logic            acc [MAXC];

  mat_skew_feeder #(
    .N      (N),
    .DATA_W (DW),
    .K_MAX  (KMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .in_last    (inLast),
    .out_data   (outData),
    .out_valid  (outValid),
    .frame_done (frameDone),
    .len_err    (lenErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N*DW-1:0] d, input logic l, input logic r);
    inValid = v;
    inData  = d;
    inLast  = l;
    reset   = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearVectors();
    for (int c = 0; c < MAXC; c++) begin
      stV[c] = 1'b0;
      stL[c] = 1'b0;
      stR[c] = 1'b0;
      stD[c] = '0;
      exR[c] = 1'b1;
      exF[c] = 1'b0;
      exE[c] = 1'b0;
    end
  endtask

  // Beat b lane i reaches the output in cycle b+1+i unless a reset was sampled
  // on any edge from its acceptance up to that cycle.
  task automatic expectLane(input int c, input int i, output logic v, output lane_t d);
    int b;
    b = c - 1 - i;
    v = 1'b0;
    d = '0;
    if (b >= 0) begin
      v = acc[b];
      for (int k = b; k <= c - 1; k++) begin
        if (stR[k]) v = 1'b0;
      end
      if (v) d = stD[b][i*DW +: DW];
    end
  endtask

  task automatic runVector(input string name, input int nCyc);
    logic  ev;
    lane_t ed;
    for (int b = 0; b < MAXC; b++) begin
      acc[b] = stV[b] && exR[b] && !stR[b];
    end
    for (int c = 0; c <= nCyc; c++) begin
      if (c > 0) begin
        checkOutput($sformatf("%s c%0d in_ready", name, c), 32'(inReady), 32'(exR[c]));
        checkOutput($sformatf("%s c%0d frame_done", name, c), 32'(frameDone), 32'(exF[c]));
        checkOutput($sformatf("%s c%0d len_err", name, c), 32'(lenErr), 32'(exE[c]));
        for (int i = 0; i < N; i++) begin
          expectLane(c, i, ev, ed);
          checkOutput($sformatf("%s c%0d lane%0d valid", name, c, i), 32'(outValid[i]), 32'(ev));
          if (ev) begin
            checkOutput($sformatf("%s c%0d lane%0d data", name, c, i), 32'(outData[i*DW +: DW]), 32'(ed));
          end
`ifdef SKEW_ZERO_FILL_EN
          else begin
            checkOutput($sformatf("%s c%0d lane%0d zero", name, c, i), 32'(outData[i*DW +: DW]), 32'h0);
          end
`endif
        end
      end
      if (c < nCyc) begin
        applyStimulus(stV[c], stD[c], stL[c], stR[c]);
        tick();
      end
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] reset then idle");
    clearVectors();
    stR[0] = 1'b1;
    stR[1] = 1'b1;
    runVector("idle", 12);

    $display("[TB] skew timing");
    clearVectors();
    stV[0] = 1'b1; stD[0] = 32'h04030201;
    stV[1] = 1'b1; stD[1] = 32'h08070605;
    stV[2] = 1'b1; stD[2] = 32'h0c0b0a09; stL[2] = 1'b1;
    exR[3] = 1'b0; exR[4] = 1'b0; exR[5] = 1'b0;
    exF[6] = 1'b1;
    runVector("skew", 8);
    checkOutput("skew c8 lane3 data", 32'(outData[3*DW +: DW]), 32'h0);

    $display("[TB] bubble");
    clearVectors();
    stV[0] = 1'b1; stD[0] = 32'h14131211;
    stV[2] = 1'b1; stD[2] = 32'h24232221; stL[2] = 1'b1;
    exR[3] = 1'b0; exR[4] = 1'b0; exR[5] = 1'b0;
    exF[6] = 1'b1;
    runVector("bubble", 8);

    $display("[TB] single-beat frame");
    clearVectors();
    stV[0] = 1'b1; stD[0] = 32'ha4a3a2a1; stL[0] = 1'b1;
    exR[1] = 1'b0; exR[2] = 1'b0; exR[3] = 1'b0;
    exF[4] = 1'b1;
    runVector("k1", 6);

    $display("[TB] length overflow");
    clearVectors();
    for (int b = 0; b < KMAX; b++) begin
      stV[b] = 1'b1;
      stD[b] = {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)};
    end
    for (int c = KMAX; c < KMAX + 3; c++) begin
      stV[c] = 1'b1;
      stD[c] = 32'heeeeeeee;
      exR[c] = 1'b0;
    end
    exE[KMAX]     = 1'b1;
    exF[KMAX + 3] = 1'b1;
    runVector("ovf", KMAX + 6);

    $display("[TB] last beat at K_MAX");
    clearVectors();
    for (int b = 0; b < KMAX; b++) begin
      stV[b] = 1'b1;
      stD[b] = {8'(b+64), 8'(b+48), 8'(b+32), 8'(b+16)};
    end
    stL[KMAX-1] = 1'b1;
    exR[KMAX] = 1'b0; exR[KMAX+1] = 1'b0; exR[KMAX+2] = 1'b0;
    exF[KMAX + 3] = 1'b1;
    runVector("lastmax", KMAX + 5);

    $display("[TB] reset mid-drain");
    clearVectors();
    stV[0] = 1'b1; stD[0] = 32'h55443322; stL[0] = 1'b1;
    stR[1] = 1'b1;
    exR[1] = 1'b0;
    runVector("rstdrain", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
